// File: rtl/bram_arbiter_pkg.sv
// Shared types for the two-port BRAM arbiter: request payload and FSM state.
package bram_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef struct packed {
        logic              valid;
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bram_req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bram_arbiter_slot.sv
// One-entry request buffer for one upstream port; holds the request until its completion.
module bram_arbiter_slot
    import bram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              instr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              done,
    output logic              occupied,
    output bram_req_t         req_c
);

    bram_req_t stored_q;
    bram_req_t incoming;
    logic      capture;

    // A new request is accepted when the slot is empty or its current request completes now.
    always_comb begin
        capture  = valid && (!occupied || done);
        incoming = '{valid: capture, instr: instr, addr: addr, wdata: wdata, wstrb: wstrb};
        req_c    = (occupied && !done) ? stored_q : incoming;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            occupied <= 1'b0;
            stored_q <= '0;
        end else if (capture) begin
            occupied <= 1'b1;
            stored_q <= incoming;
        end else if (done) begin
            occupied <= 1'b0;
        end
    end

endmodule

// File: rtl/bram_arbiter.sv
// Two-port (fetch/data) arbiter onto a single BRAM port with alternating-priority grants.
module bram_arbiter
    import bram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid,
    input  logic              imem_instr,
    input  logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_wdata,
    input  logic [STRB_W-1:0] imem_wstrb,
    output logic [DATA_W-1:0] imem_rdata,
    output logic              imem_ready,
    input  logic              dmem_valid,
    input  logic              dmem_instr,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_wdata,
    input  logic [STRB_W-1:0] dmem_wstrb,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              dmem_ready,
    output logic              bram_valid,
    output logic              bram_instr,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic [STRB_W-1:0] bram_wstrb,
    input  logic [DATA_W-1:0] bram_rdata,
    input  logic              bram_ready
);

    arb_state_t state_q, state_d;
    logic       last_i_q, last_i_d;
    bram_req_t  bram_q, bram_d;
    bram_req_t  req_i_c, req_d_c;
    logic       occ_i, occ_d;
    logic       done_i_c, done_d_c;
    logic       can_issue, grant_i, grant_d;

    assign done_i_c = (state_q == BUSY_I) && bram_ready;
    assign done_d_c = (state_q == BUSY_D) && bram_ready;

    bram_arbiter_slot u_slot_i (
        .clk      (clk),
        .rst      (rst),
        .valid    (imem_valid),
        .instr    (imem_instr),
        .addr     (imem_addr),
        .wdata    (imem_wdata),
        .wstrb    (imem_wstrb),
        .done     (done_i_c),
        .occupied (occ_i),
        .req_c    (req_i_c)
    );

    bram_arbiter_slot u_slot_d (
        .clk      (clk),
        .rst      (rst),
        .valid    (dmem_valid),
        .instr    (dmem_instr),
        .addr     (dmem_addr),
        .wdata    (dmem_wdata),
        .wstrb    (dmem_wstrb),
        .done     (done_d_c),
        .occupied (occ_d),
        .req_c    (req_d_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_i_q <= 1'b1;
            bram_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
            bram_q   <= bram_d;
        end
    end

    // Grant whenever the port is free; on a tie the port not granted last wins.
    always_comb begin
        state_d       = state_q;
        last_i_d      = last_i_q;
        bram_d        = bram_q;
        bram_d.valid  = 1'b0;
        can_issue     = 1'b0;
        grant_i       = 1'b0;
        grant_d       = 1'b0;

        case (state_q)
            IDLE:    can_issue = 1'b1;
            BUSY_I:  can_issue = bram_ready;
            BUSY_D:  can_issue = bram_ready;
            default: can_issue = 1'b1;
        endcase

        if (can_issue) begin
            grant_i = req_i_c.valid && (!req_d_c.valid || !last_i_q);
            grant_d = req_d_c.valid && !grant_i;
            if (grant_i) begin
                bram_d   = req_i_c;
                state_d  = BUSY_I;
                last_i_d = 1'b1;
            end else if (grant_d) begin
                bram_d   = req_d_c;
                state_d  = BUSY_D;
                last_i_d = 1'b0;
            end else begin
                state_d  = IDLE;
            end
        end
    end

    assign imem_ready = done_i_c;
    assign dmem_ready = done_d_c;
    assign imem_rdata = done_i_c ? bram_rdata : '0;
    assign dmem_rdata = done_d_c ? bram_rdata : '0;

    assign bram_valid = bram_q.valid;
    assign bram_instr = bram_q.instr;
    assign bram_addr  = bram_q.addr;
    assign bram_wdata = bram_q.wdata;
    assign bram_wstrb = bram_q.wstrb;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: directed requests, BRAM model, decoupled monitor.
module tb_bram_arbiter;

    bit          clk = 1'b0;
    logic        rst;
    logic        imem_valid, imem_instr, imem_ready;
    logic [31:0] imem_addr, imem_wdata, imem_rdata;
    logic [3:0]  imem_wstrb;
    logic        dmem_valid, dmem_instr, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        bram_valid, bram_instr, bram_ready;
    logic [31:0] bram_addr, bram_wdata, bram_rdata;
    logic [3:0]  bram_wstrb;

    bram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .imem_valid (imem_valid),
        .imem_instr (imem_instr),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_wstrb (imem_wstrb),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_instr (dmem_instr),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } iss_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        wr;
    } rsp_t;

    iss_t exp_b[$];
    rsp_t exp_i[$];
    rsp_t exp_d[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: completes one cycle after each request, byte-strobed writes.
    logic [31:0] mem [0:255];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem_init   <= 1'b1;
            bram_ready <= 1'b0;
            bram_rdata <= '0;
        end else begin
            bram_ready <= bram_valid;
            if (bram_valid) begin
                bram_rdata <= mem[bram_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (bram_wstrb[b]) mem[bram_addr[9:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_iss(input int c, input logic ins, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] ws);
        iss_t e;
        e.cyc = c; e.instr = ins; e.addr = a; e.wdata = wd; e.wstrb = ws;
        exp_b.push_back(e);
    endtask

    task automatic push_rsp(input bit dport, input int c, input logic [31:0] rd, input logic wr);
        rsp_t r;
        r.cyc = c; r.rdata = rd; r.wr = wr;
        if (dport) exp_d.push_back(r);
        else       exp_i.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues or completes.
    iss_t e_m, last_iss;
    rsp_t r_m;
    bit   have_last = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bram_valid) begin
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_issue: got addr %h expected none (cycle %0d)", bram_addr, cyc);
                end else begin
                    e_m = exp_b.pop_front();
                    chk("issue_cycle", 32'(cyc), 32'(e_m.cyc));
                    chk("issue_addr", bram_addr, e_m.addr);
                    chk("issue_instr", 32'(bram_instr), 32'(e_m.instr));
                    chk("issue_wdata", bram_wdata, e_m.wdata);
                    chk("issue_wstrb", 32'(bram_wstrb), 32'(e_m.wstrb));
                    last_iss  = e_m;
                    have_last = 1'b1;
                end
            end else if (have_last) begin
                chk("hold_addr", bram_addr, last_iss.addr);
                chk("hold_wstrb", 32'(bram_wstrb), 32'(last_iss.wstrb));
            end
            if (!rst) have_last = 1'b0;

            if (imem_ready) begin
                if (exp_i.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_imem_ready: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r_m = exp_i.pop_front();
                    chk("imem_ready_cycle", 32'(cyc), 32'(r_m.cyc));
                    if (!r_m.wr) chk("imem_rdata", imem_rdata, r_m.rdata);
                end
            end else begin
                chk("imem_rdata_idle", imem_rdata, 32'h0);
            end

            if (dmem_ready) begin
                if (exp_d.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_dmem_ready: got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    r_m = exp_d.pop_front();
                    chk("dmem_ready_cycle", 32'(cyc), 32'(r_m.cyc));
                    if (!r_m.wr) chk("dmem_rdata", dmem_rdata, r_m.rdata);
                end
            end else begin
                chk("dmem_rdata_idle", dmem_rdata, 32'h0);
            end
        end
    end

    int t0;
    int ji, jd;
    logic [31:0] itab [4];
    logic [31:0] dtab [4];

    initial begin
        rst = 1'b0;
        imem_valid = 1'b0; imem_instr = 1'b0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
        dmem_valid = 1'b0; dmem_instr = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        itab[0] = 32'hA500_0040; itab[1] = 32'hA500_0041; itab[2] = 32'hA500_0042; itab[3] = 32'hA500_0043;
        dtab[0] = 32'hDEAD_BEEF; dtab[1] = 32'hA500_0081; dtab[2] = 32'hA500_0082; dtab[3] = 32'hA500_0083;

        repeat (3) step();
        chk("rst_bram_valid", 32'(bram_valid), 32'h0);
        chk("rst_bram_instr", 32'(bram_instr), 32'h0);
        chk("rst_bram_addr", bram_addr, 32'h0);
        chk("rst_bram_wdata", bram_wdata, 32'h0);
        chk("rst_bram_wstrb", 32'(bram_wstrb), 32'h0);
        chk("rst_imem_ready", 32'(imem_ready), 32'h0);
        chk("rst_dmem_ready", 32'(dmem_ready), 32'h0);
        mon_en = 1'b1;
        step();
        rst = 1'b1;

        // Single imem read: issue N+1, ready N+2
        step(); t0 = cyc;
        push_iss(t0 + 1, 1'b1, 32'h100, 32'h0, 4'h0);
        push_rsp(1'b0, t0 + 2, 32'hA500_0040, 1'b0);
        imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h100; imem_wdata = '0; imem_wstrb = '0;
        step(); imem_valid = 1'b0;
        repeat (4) step();

        // Simultaneous requests: dmem write wins, imem served right after
        step(); t0 = cyc;
        push_iss(t0 + 1, 1'b0, 32'h200, 32'hDEAD_BEEF, 4'hF);
        push_rsp(1'b1, t0 + 2, 32'h0, 1'b1);
        push_iss(t0 + 3, 1'b1, 32'h104, 32'h0, 4'h0);
        push_rsp(1'b0, t0 + 4, 32'hA500_0041, 1'b0);
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = 32'h200; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
        imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h104; imem_wdata = '0; imem_wstrb = '0;
        step(); dmem_valid = 1'b0; imem_valid = 1'b0;
        repeat (6) step();

        // dmem re-asserts valid while in flight: must be ignored
        step(); t0 = cyc;
        push_iss(t0 + 1, 1'b0, 32'h200, 32'h0, 4'h0);
        push_rsp(1'b1, t0 + 2, 32'hDEAD_BEEF, 1'b0);
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = 32'h200; dmem_wdata = '0; dmem_wstrb = '0;
        step(); dmem_addr = 32'h204;
        step(); dmem_valid = 1'b0;
        repeat (4) step();

        // Reset mid-transaction abandons it; valid during reset is not captured
        step(); t0 = cyc;
        push_iss(t0 + 1, 1'b1, 32'h108, 32'h0, 4'h0);
        imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h108; imem_wdata = '0; imem_wstrb = '0;
        step();
        imem_valid = 1'b0; rst = 1'b0;
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = 32'h20C; dmem_wdata = '0; dmem_wstrb = '0;
        step();
        rst = 1'b1; dmem_valid = 1'b0;
        chk("mid_rst_bram_valid", 32'(bram_valid), 32'h0);
        chk("mid_rst_bram_addr", bram_addr, 32'h0);
        chk("mid_rst_bram_instr", 32'(bram_instr), 32'h0);
        chk("mid_rst_imem_ready", 32'(imem_ready), 32'h0);
        chk("mid_rst_dmem_ready", 32'(dmem_ready), 32'h0);
        repeat (2) step(); t0 = cyc;
        push_iss(t0 + 1, 1'b1, 32'h10C, 32'h0, 4'h0);
        push_rsp(1'b0, t0 + 2, 32'hA500_0043, 1'b0);
        imem_valid = 1'b1; imem_addr = 32'h10C;
        step(); imem_valid = 1'b0;
        repeat (3) step();

        // Both ports re-request on every ready: strict D,I,D,I alternation
        step(); t0 = cyc;
        for (int j = 0; j < 4; j++) begin
            push_iss(t0 + 1 + 4*j, 1'b0, 32'h200 + 32'(4*j), 32'h0, 4'h0);
            push_iss(t0 + 3 + 4*j, 1'b1, 32'h100 + 32'(4*j), 32'h0, 4'h0);
            push_rsp(1'b1, t0 + 2 + 4*j, dtab[j], 1'b0);
            push_rsp(1'b0, t0 + 4 + 4*j, itab[j], 1'b0);
        end
        imem_valid = 1'b1; imem_instr = 1'b1; imem_addr = 32'h100; imem_wdata = '0; imem_wstrb = '0;
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = 32'h200; dmem_wdata = '0; dmem_wstrb = '0;
        ji = 1; jd = 1;
        for (int k = 0; k < 20; k++) begin
            step();
            imem_valid = 1'b0;
            dmem_valid = 1'b0;
            if (imem_ready && ji < 4) begin
                imem_valid = 1'b1; imem_addr = 32'h100 + 32'(4*ji); ji++;
            end
            if (dmem_ready && jd < 4) begin
                dmem_valid = 1'b1; dmem_addr = 32'h200 + 32'(4*jd); jd++;
            end
        end
        imem_valid = 1'b0; dmem_valid = 1'b0;
        repeat (2) step();

        // Byte write then back-to-back read of the same word
        step(); t0 = cyc;
        push_iss(t0 + 1, 1'b0, 32'h300, 32'h0000_AB00, 4'h2);
        push_rsp(1'b1, t0 + 2, 32'h0, 1'b1);
        push_iss(t0 + 3, 1'b0, 32'h300, 32'h0, 4'h0);
        push_rsp(1'b1, t0 + 4, 32'hA500_ABC0, 1'b0);
        dmem_valid = 1'b1; dmem_instr = 1'b0; dmem_addr = 32'h300; dmem_wdata = 32'h0000_AB00; dmem_wstrb = 4'h2;
        step(); dmem_valid = 1'b0;
        step(); dmem_valid = 1'b1; dmem_wdata = '0; dmem_wstrb = '0;
        step(); dmem_valid = 1'b0;
        repeat (4) step();

        chk("pending_issues", 32'(exp_b.size()), 32'h0);
        chk("pending_imem", 32'(exp_i.size()), 32'h0);
        chk("pending_dmem", 32'(exp_d.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameters: none; all data and address widths fixed at 32 bits, strobes at 4 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 imem_valid/imem_instr  in  1/1  fetch-port request pulse / instruction-access flag.
REQ-005 imem_addr/imem_wdata/imem_wstrb  in  32/32/4  fetch-port address, write data, byte strobes.
REQ-006 imem_rdata/imem_ready  out  32/1  fetch-port read data / one-cycle completion pulse.
REQ-007 dmem_valid, dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb, dmem_rdata, dmem_ready: same widths, directions and meanings as the imem port, for the data port.
REQ-008 bram_valid/bram_instr  out  1/1  memory request pulse / instruction flag, registered.
REQ-009 bram_addr/bram_wdata/bram_wstrb  out  32/32/4  memory request fields, registered.
REQ-010 bram_rdata/bram_ready  in  32/1  memory read data / completion pulse, one cycle after bram_valid.

Function
REQ-011 Each port SHALL own a one-entry buffer capturing instr/addr/wdata/wstrb on any cycle where its valid=1 and no request from that port is buffered or in flight.
REQ-012 valid on a port whose request is buffered or in flight SHALL be ignored, except in the cycle that port's ready=1, when it SHALL be captured (back-to-back).
REQ-013 FSM states: IDLE, BUSY_I, BUSY_D.
REQ-014 IDLE: if a request (buffered or arriving this cycle) exists, grant it, register it onto bram_* for the next cycle with bram_valid=1, go to BUSY_I/BUSY_D; else stay.
REQ-015 Arbitration when both ports have a request: grant the port not granted last; after reset the last-grant pointer SHALL point at imem (dmem wins first tie).
REQ-016 bram_valid SHALL be high exactly one cycle per granted request.
REQ-017 BUSY_x with bram_ready=1: assert x_ready=1 and x_rdata=bram_rdata combinationally in the same cycle; free x's buffer; apply REQ-014 in that same cycle (next grant may issue with no IDLE bubble).
REQ-018 BUSY_x with bram_ready=0: hold state; bram_valid=0.
REQ-019 bram_ready in IDLE SHALL be ignored (no upstream ready).
REQ-020 Latency: valid in cycle N, idle arbiter -> bram_valid in N+1 -> x_ready in N+2; peak throughput one transaction per two cycles.
REQ-021 Writes (wstrb!=0) and reads SHALL follow identical timing; x_ready SHALL pulse for writes, x_rdata then don't-care.
REQ-022 The ready of the non-granted port SHALL be 0; x_rdata SHALL be 0 when x_ready=0.
REQ-023 bram_addr/wdata/wstrb/instr SHALL hold their last value while bram_valid=0.

Reset
REQ-024 rst=0 at a rising edge: state IDLE, both buffers empty, last-grant=imem, all bram_* outputs 0, imem_ready=dmem_ready=0.
REQ-025 Reset mid-transaction SHALL abandon it: no ready for it, and a bram_ready arriving after reset is ignored per REQ-019.
REQ-026 valid presented while rst=0 SHALL not be captured.

Structure
REQ-027 The shared configuration package SHALL hold the request struct typedef (valid, instr, addr, wdata, wstrb) and the FSM state enum.
REQ-028 One sub-module, bram_arbiter_slot (the one-entry per-port buffer with occupied flag), SHALL be instantiated twice.

Verification
REQ-029 imem read 0x00000100 alone in cycle 0 -> bram_valid=1 addr 0x100 instr=1 in cycle 1; imem_ready=1 with memory word in cycle 2.
REQ-030 imem and dmem valid together in cycle 0 (dmem write 0x200, data 0xDEADBEEF, wstrb 0xF) -> dmem issued cycle 1, dmem_ready cycle 2, imem issued cycle 3, imem_ready cycle 4.
REQ-031 Both ports re-request on every ready for 8 transactions -> grants strictly alternate D,I,D,I; no port waits more than one other transaction.
REQ-032 dmem_valid asserted again in cycle 1 while its request is in flight -> ignored; exactly one bram_valid and one dmem_ready.
REQ-033 rst=0 in cycle 1 after imem valid in cycle 0 -> no imem_ready, bram_ready in cycle 2 ignored, all outputs 0, next request after reset served with REQ-029 timing.
REQ-034 Byte write wstrb=0x2 data 0x0000AB00 to 0x300 then read 0x300 -> bram_wstrb=0x2 on issue; read returns byte 1 = 0xAB.
